// File: rtl/cpu15_pkg.sv
// Shared constants for the 15-bit CPU core: widths, instruction field positions,
// opcode names and the fetch/decode FSM state encoding.
package cpu15_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 8;
    localparam int INST_W  = 15;
    localparam int REG_NUM = 8;
    localparam int SEL_W   = $clog2(REG_NUM);

    // Instruction fields; rb and op_data deliberately overlap
    localparam int OPC_MSB = 14;
    localparam int OPC_LSB = 11;
    localparam int RA_MSB  = 10;
    localparam int RB_MSB  = 7;
    localparam int OPD_MSB = 7;

    typedef enum logic [3:0] {
        OP_MOV = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_SHL = 4'h6,
        OP_SHR = 4'h7,
        OP_LDL = 4'h8,
        OP_LDH = 4'h9,
        OP_CMP = 4'ha,
        OP_JE  = 4'hb,
        OP_JMP = 4'hc,
        OP_LD  = 4'hd,
        OP_ST  = 4'he,
        OP_HLT = 4'hf
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/reg_file.sv
// Register file: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear of every entry.
module reg_file
    import cpu15_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int DEPTH = REG_NUM,
    parameter int SW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [SW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [SW-1:0] raddr_a,
    input  logic [SW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: the array is reset on purpose -- every register must read zero after
    // reset, so this storage maps to flops, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/fetch_decode.sv
// Front end of the 15-bit CPU: fetch from ROM, decode, read the register file,
// strobe exec, then write back and adopt exec's PC. Optional FETCH_DECODE_STEP_EN.
module fetch_decode
    import cpu15_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [INST_W-1:0] ROM_DATA,
    output logic [3:0]        OP_CODE,
    output logic [DATA_W-1:0] REG_A,
    output logic [DATA_W-1:0] REG_B,
    output logic [7:0]        OP_DATA,
    output logic              EX_EN,
    input  logic [ADDR_W-1:0] P_COUNT,
    input  logic [DATA_W-1:0] REG_IN,
    input  logic              REG_WEN,
`ifdef FETCH_DECODE_STEP_EN
    input  logic              STEP,
    output logic              STEP_WAIT,
`endif
    output logic              HALTED
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [INST_W-1:0] ir_q;
    logic              fetch_go;
    logic [SEL_W-1:0]  ra;
    logic [SEL_W-1:0]  rb;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic              rf_we;

    assign ra = ir_q[RA_MSB -: SEL_W];
    assign rb = ir_q[RB_MSB -: SEL_W];

`ifdef FETCH_DECODE_STEP_EN
    assign fetch_go  = STEP;
    assign STEP_WAIT = (state_q == S_FETCH);
`else
    assign fetch_go  = 1'b1;
`endif

    // Writeback lands before the next DECODE, so no read bypass is needed
    assign rf_we = (state_q == S_WB) && REG_WEN;

    reg_file #(
        .DW    (DATA_W),
        .DEPTH (REG_NUM)
    ) u_reg_file (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .we      (rf_we),
        .waddr   (ra),
        .wdata   (REG_IN),
        .raddr_a (ra),
        .raddr_b (rb),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (fetch_go) state_d = S_DECODE;
            S_DECODE: state_d = (ir_q[OPC_MSB:OPC_LSB] == OP_HLT) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // NOTE: non-blocking assignments keep every register updating from the
    // pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            OP_CODE <= '0;
            OP_DATA <= '0;
            REG_A   <= '0;
            REG_B   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && fetch_go) begin
                ir_q <= ROM_DATA;
            end
            if (state_q == S_DECODE) begin
                OP_CODE <= ir_q[OPC_MSB:OPC_LSB];
                OP_DATA <= ir_q[OPD_MSB:0];
                REG_A   <= rf_a;
                REG_B   <= rf_b;
            end
            // Exec computes every PC change; wrap from 8'hff is taken as given
            if (state_q == S_WB) begin
                pc_q <= P_COUNT;
            end
        end
    end

    assign ROM_ADDR = pc_q;
    assign EX_EN    = (state_q == S_EXEC);
    assign HALTED   = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_decode.sv
// Randomized self-checking bench for fetch_decode: the bench plays ROM and exec,
// and keeps an instruction-level model (PC plus register array) of the front end.
module tb_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rom_addr;
    logic [14:0] rom_data;
    logic [3:0]  op_code;
    logic [15:0] reg_a;
    logic [15:0] reg_b;
    logic [7:0]  op_data;
    logic        ex_en;
    logic [7:0]  p_count;
    logic [15:0] reg_in;
    logic        reg_wen;
    logic        halted;
`ifdef FETCH_DECODE_STEP_EN
    logic        step;
    logic        step_wait;
`endif

    logic [14:0] rom [256];
    logic [15:0] m_rf [8];
    logic [7:0]  m_pc;

    int vectors;
    int miscompares;

    assign rom_data = rom[rom_addr];

    fetch_decode dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .ROM_ADDR  (rom_addr),
        .ROM_DATA  (rom_data),
        .OP_CODE   (op_code),
        .REG_A     (reg_a),
        .REG_B     (reg_b),
        .OP_DATA   (op_data),
        .EX_EN     (ex_en),
        .P_COUNT   (p_count),
        .REG_IN    (reg_in),
        .REG_WEN   (reg_wen),
`ifdef FETCH_DECODE_STEP_EN
        .STEP      (step),
        .STEP_WAIT (step_wait),
`endif
        .HALTED    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Exec-side outputs are garbage outside the writeback cycle; the DUT must ignore them
    task automatic drive_junk();
        reg_wen = 1'b1;
        reg_in  = 16'($urandom);
        p_count = 8'($urandom);
    endtask

    function automatic logic [14:0] rand_inst();
        logic [3:0] opc;
        opc = 4'($urandom_range(0, 14));
        return {opc, 11'($urandom)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
        m_pc = 8'h00;
    endtask

    // Entered in the low phase of a FETCH cycle; leaves in the low phase of the next FETCH
    task automatic run_instr(input logic wen, input logic [15:0] din, input logic [7:0] npc,
                             output logic hlt);
        logic [14:0] inst;
        logic [3:0]  opc;
        logic [2:0]  ra;
        logic [2:0]  rb;
        inst = rom[m_pc];
        opc  = inst[14:11];
        ra   = inst[10:8];
        rb   = inst[7:5];
        hlt  = 1'b0;
        check("fetch_rom_addr", 32'(rom_addr), 32'(m_pc));
        check("fetch_ex_en", 32'(ex_en), 32'd0);
        drive_junk();
        @(negedge clk);
        check("decode_ex_en", 32'(ex_en), 32'd0);
        @(negedge clk);
        if (opc == 4'hf) begin
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_ex_en", 32'(ex_en), 32'd0);
            hlt = 1'b1;
            return;
        end
        check("exec_ex_en", 32'(ex_en), 32'd1);
        check("exec_op_code", 32'(op_code), 32'(opc));
        check("exec_op_data", 32'(op_data), 32'(inst[7:0]));
        check("exec_reg_a", 32'(reg_a), 32'(m_rf[ra]));
        check("exec_reg_b", 32'(reg_b), 32'(m_rf[rb]));
        drive_junk();
        @(negedge clk);
        check("wb_ex_en", 32'(ex_en), 32'd0);
        reg_wen = wen;
        reg_in  = din;
        p_count = npc;
        if (wen) m_rf[ra] = din;
        m_pc = npc;
        @(negedge clk);
    endtask

    logic        h;
    logic [7:0]  npc;
    int          pulses;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        reg_wen     = 1'b0;
        reg_in      = 16'h0000;
        p_count     = 8'h00;
`ifdef FETCH_DECODE_STEP_EN
        step        = 1'b1;
`endif
        for (int i = 0; i < 256; i++) rom[i] = rand_inst();
        rom[0]    = {4'h8, 3'd1, 8'h07};
        rom[1]    = {4'h1, 3'd2, 3'd1, 5'd0};
        rom[2]    = {4'hc, 3'd0, 8'h40};
        rom[3]    = {4'hf, 11'd0};
        rom[8'h40] = {4'h0, 3'd3, 3'd2, 5'd0};
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rom_addr", 32'(rom_addr), 32'h00);
        check("rst_ex_en", 32'(ex_en), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_op_code", 32'(op_code), 32'd0);
        check("rst_op_data", 32'(op_data), 32'd0);
        check("rst_reg_a", 32'(reg_a), 32'd0);
        check("rst_reg_b", 32'(reg_b), 32'd0);
        rst_n = 1'b1;

        // Directed program: LDL, dependent read, JMP, return, HLT
        run_instr(1'b1, 16'h0007, 8'h01, h);
        run_instr(1'b0, 16'h0000, 8'h02, h);
        check("ldl_reg_b", 32'(reg_b), 32'h0007);
        check("ldl_op_code", 32'(op_code), 32'h1);
        run_instr(1'b0, 16'h0000, 8'h40, h);
        check("jmp_rom_addr", 32'(rom_addr), 32'h40);
        run_instr(1'b1, 16'h1234, 8'h03, h);
        run_instr(1'b0, 16'h0000, 8'h04, h);
        check("hlt_seen", 32'(h), 32'd1);
        for (int i = 0; i < 20; i++) begin
            drive_junk();
            @(negedge clk);
            check("halt_hold_ex_en", 32'(ex_en), 32'd0);
            check("halt_hold_halted", 32'(halted), 32'd1);
            check("halt_hold_rom_addr", 32'(rom_addr), 32'h03);
            check("halt_hold_op_code", 32'(op_code), 32'hf);
        end

        // Leave HALT by reset; ROM gets a HLT-free random program
        for (int i = 0; i < 256; i++) rom[i] = rand_inst();
        rst_n = 1'b0;
        #1;
        check("halt_rst_halted", 32'(halted), 32'd0);
        check("halt_rst_rom_addr", 32'(rom_addr), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Random instructions with random writebacks and PC redirects, incl. 8'hff wrap
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 15))
                11, 12, 13: npc = 8'($urandom);
                14, 15:     npc = 8'hff;
                default:    npc = 8'(m_pc + 8'd1);
            endcase
            run_instr(1'($urandom), 16'($urandom), npc, h);
        end

        // Reset asserted asynchronously in the middle of a writeback cycle
        rom[m_pc] = {4'h8, 3'd5, 8'hef};
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reg_wen = 1'b1;
        reg_in  = 16'hbeef;
        p_count = 8'h55;
        #2 rst_n = 1'b0;
        #1;
        check("midop_rom_addr", 32'(rom_addr), 32'h00);
        check("midop_ex_en", 32'(ex_en), 32'd0);
        check("midop_reg_a", 32'(reg_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        rom[0] = {4'h1, 3'd5, 3'd5, 5'd0};
        run_instr(1'b0, 16'h0000, 8'h01, h);
        check("midop_rf_cleared", 32'(reg_a), 32'h0000);

`ifdef FETCH_DECODE_STEP_EN
        // Single-step: idle with STEP low, then one pulse gives one instruction
        step = 1'b0;
        rom[m_pc] = {4'h0, 11'd0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("step_wait_high", 32'(step_wait), 32'd1);
            check("step_idle_ex_en", 32'(ex_en), 32'd0);
        end
        reg_wen = 1'b0;
        p_count = 8'(m_pc + 8'd1);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        check("step_ex_en_pulse", 32'(ex_en), 32'd1);
        pulses = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ex_en) pulses++;
        end
        check("step_single_pulse", 32'(pulses), 32'd1);
`else
        pulses = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
